pru_status_responder: RTL and testbench

- Bus responder (slave) that serves CPU reads of PRU status and activity counters; the read-direction counterpart to the PRU command-write path.
- Sits on the CPU bus master interface beside the PRU preprocessing block. Drives read data and its own ack; integration ORs its ack with the other responders.
- Also accepts CPU writes that clear flags and counters. Events come from the PRU start/busy/done handshake.

---
 rtl/pru_bus_pkg.sv | 20 ++
 rtl/pru_event_counters.sv | 56 +++++
 rtl/pru_status_responder.sv | 144 ++++++++++++++
 tb/tb_pru_status_responder.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/pru_bus_pkg.sv
// Shared constants and FSM state type for the PRU status responder.
// Optional PRU_IRQ_EN feature is handled in pru_status_responder.
package pru_bus_pkg;

    localparam logic [1:0] OFF_STATUS = 2'd0;
    localparam logic [1:0] OFF_START  = 2'd1;
    localparam logic [1:0] OFF_DONE   = 2'd2;
    localparam logic [1:0] OFF_BUSY   = 2'd3;

    localparam int ST_IRQ_EN = 0;
    localparam int ST_BUSY   = 1;
    localparam int ST_DONE   = 2;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACK     = 2'd1,
        S_RELEASE = 2'd2
    } state_e;

endpackage

// File: rtl/pru_event_counters.sv
// PRU start/done/busy event counters and the done sticky flag.
// Events in the same cycle as a clear win over the clear.
module pru_event_counters #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_busy,
    input  logic             i_done,
    input  logic             i_clr_cnt,
    input  logic             i_clr_sticky,
    output logic [CNT_W-1:0] o_start_cnt,
    output logic [CNT_W-1:0] o_done_cnt,
    output logic [31:0]      o_busy_cyc,
    output logic             o_done_sticky
);

    logic [CNT_W-1:0] r_start_cnt;
    logic [CNT_W-1:0] r_done_cnt;
    logic [31:0]      r_busy_cyc;
    logic             r_done_sticky;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_start_cnt   <= '0;
            r_done_cnt    <= '0;
            r_busy_cyc    <= '0;
            r_done_sticky <= 1'b0;
        end else begin
            if (i_clr_cnt) begin
                r_start_cnt <= CNT_W'(i_start);
                r_done_cnt  <= CNT_W'(i_done);
                r_busy_cyc  <= 32'(i_busy);
            end else begin
                if (i_start)
                    r_start_cnt <= r_start_cnt + CNT_W'(1);
                if (i_done)
                    r_done_cnt <= r_done_cnt + CNT_W'(1);
                // busy cycle count saturates instead of wrapping
                if (i_busy && (r_busy_cyc != 32'hFFFF_FFFF))
                    r_busy_cyc <= r_busy_cyc + 32'd1;
            end
            if (i_done)
                r_done_sticky <= 1'b1;
            else if (i_clr_sticky)
                r_done_sticky <= 1'b0;
        end
    end

    assign o_start_cnt   = r_start_cnt;
    assign o_done_cnt    = r_done_cnt;
    assign o_busy_cyc    = r_busy_cyc;
    assign o_done_sticky = r_done_sticky;

endmodule

// File: rtl/pru_status_responder.sv
// Bus responder for PRU status/counter reads and clear writes.
// Define PRU_IRQ_EN to add the irq_en flag and registered pru_irq_o.
module pru_status_responder
    import pru_bus_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_4000,
    parameter int          CNT_W     = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] b_addr_i,
    input  logic [31:0] b_data_i,
    input  logic        b_read_i,
    input  logic        b_write_i,
    output logic [31:0] b_data_o,
    output logic        b_ack_o,
    input  logic        pru_start_i,
    input  logic        pru_busy_i,
    input  logic        pru_done_i
`ifdef PRU_IRQ_EN
    ,
    output logic        pru_irq_o
`endif
);

    state_e           r_state;
    logic [1:0]       r_off;
    logic             r_wr;
    logic             r_wd_clr;
    logic             r_wd_ien;
    logic [31:0]      r_rdata;

    logic             w_req;
    logic             w_hit;
    logic             w_ack;
    logic             w_wr_fire;
    logic             w_clr_cnt;
    logic             w_clr_sticky;
    logic             w_irq_en;
    logic [31:0]      w_rdata;
    logic [CNT_W-1:0] w_start_cnt;
    logic [CNT_W-1:0] w_done_cnt;
    logic [31:0]      w_busy_cyc;
    logic             w_done_sticky;

    assign w_req = b_read_i | b_write_i;
    assign w_hit = (b_addr_i[31:4] == BASE_ADDR[31:4]);

    always_comb begin
        w_rdata = '0;
        unique case (b_addr_i[3:2])
            OFF_STATUS: begin
                w_rdata[ST_DONE]   = w_done_sticky;
                w_rdata[ST_BUSY]   = pru_busy_i;
                w_rdata[ST_IRQ_EN] = w_irq_en;
            end
            OFF_START: w_rdata = 32'(w_start_cnt);
            OFF_DONE:  w_rdata = 32'(w_done_cnt);
            OFF_BUSY:  w_rdata = w_busy_cyc;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_off    <= '0;
            r_wr     <= 1'b0;
            r_wd_clr <= 1'b0;
            r_wd_ien <= 1'b0;
            r_rdata  <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_req && w_hit) begin
                        r_state  <= S_ACK;
                        r_off    <= b_addr_i[3:2];
                        r_wr     <= b_write_i;
                        r_wd_clr <= b_data_i[ST_DONE];
                        r_wd_ien <= b_data_i[ST_IRQ_EN];
                        r_rdata  <= b_write_i ? 32'h0 : w_rdata;
                    end
                end
                S_ACK: r_state <= S_RELEASE;
                // hold off until the master drops its request
                S_RELEASE: begin
                    if (!w_req)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_ack        = (r_state == S_ACK);
    assign w_wr_fire    = w_ack & r_wr;
    assign w_clr_sticky = w_wr_fire & (r_off == OFF_STATUS) & r_wd_clr;
    assign w_clr_cnt    = w_wr_fire & (r_off != OFF_STATUS);

    assign b_ack_o  = w_ack;
    assign b_data_o = w_ack ? r_rdata : 32'h0;

`ifdef PRU_IRQ_EN
    logic r_irq_en;
    logic r_irq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_wr_fire && (r_off == OFF_STATUS))
                r_irq_en <= r_wd_ien;
            r_irq <= r_irq_en & w_done_sticky;
        end
    end

    assign w_irq_en  = r_irq_en;
    assign pru_irq_o = r_irq;
    logic w_unused_bits;
    assign w_unused_bits = ^{b_addr_i[1:0], b_data_i[31:3], b_data_i[1]};
`else
    logic w_unused_bits;
    assign w_irq_en      = 1'b0;
    assign w_unused_bits = ^{b_addr_i[1:0], b_data_i[31:3], b_data_i[1],
                             r_wd_ien};
`endif

    pru_event_counters #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_start       (pru_start_i),
        .i_busy        (pru_busy_i),
        .i_done        (pru_done_i),
        .i_clr_cnt     (w_clr_cnt),
        .i_clr_sticky  (w_clr_sticky),
        .o_start_cnt   (w_start_cnt),
        .o_done_cnt    (w_done_cnt),
        .o_busy_cyc    (w_busy_cyc),
        .o_done_sticky (w_done_sticky)
    );

endmodule

// File: tb/tb_pru_status_responder.sv
// Directed bench for pru_status_responder (CNT_W=4 to reach the wrap).
// Define PRU_IRQ_EN to also exercise the interrupt path.
module tb_pru_status_responder;

    localparam logic [31:0] BASE = 32'h0000_4000;
    localparam int          CW   = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] b_addr_i = '0;
    logic [31:0] b_data_i = '0;
    logic        b_read_i = 1'b0;
    logic        b_write_i = 1'b0;
    logic [31:0] b_data_o;
    logic        b_ack_o;
    logic        pru_start_i = 1'b0;
    logic        pru_busy_i = 1'b0;
    logic        pru_done_i = 1'b0;
`ifdef PRU_IRQ_EN
    logic        pru_irq_o;
`endif

    pru_status_responder #(
        .BASE_ADDR (BASE),
        .CNT_W     (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .b_addr_i    (b_addr_i),
        .b_data_i    (b_data_i),
        .b_read_i    (b_read_i),
        .b_write_i   (b_write_i),
        .b_data_o    (b_data_o),
        .b_ack_o     (b_ack_o),
        .pru_start_i (pru_start_i),
        .pru_busy_i  (pru_busy_i),
        .pru_done_i  (pru_done_i)
`ifdef PRU_IRQ_EN
        ,
        .pru_irq_o   (pru_irq_o)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        bit          ack;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // mode: 01 read, 10 write, 11 both; ev={busy,done,start} during ACK
    task automatic acc(input logic [1:0] mode, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp,
                       input bit want_ack, input int hold,
                       input logic [2:0] ev, input string nm);
        int nack;
        int lat;
        int ncyc;
        logic [31:0] d;
        nack = 0;
        lat  = 0;
        d    = '0;
        ncyc = want_ack ? 1 + hold : 10;
        @(posedge clk); #1;
        b_addr_i  = addr;
        b_data_i  = wdata;
        b_read_i  = mode[0];
        b_write_i = mode[1];
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk); #1;
            if (b_ack_o) begin
                nack++;
                if (lat == 0) begin
                    lat = c;
                    d   = b_data_o;
                end
            end
            if (c == 1)
                {pru_busy_i, pru_done_i, pru_start_i} = ev;
            else
                {pru_busy_i, pru_done_i, pru_start_i} = 3'b000;
        end
        b_read_i  = 1'b0;
        b_write_i = 1'b0;
        @(posedge clk); #1;
        {pru_busy_i, pru_done_i, pru_start_i} = 3'b000;
        if (want_ack) begin
            chk({nm, " ack_count"}, 32'(nack), 32'd1);
            chk({nm, " latency"}, 32'(lat), 32'd1);
            chk({nm, " data"}, d, exp);
        end else begin
            chk({nm, " no_ack"}, 32'(nack), 32'd0);
        end
    endtask

    task automatic pulses(input int ns, input int nd);
        for (int i = 0; i < ns; i++) begin
            @(posedge clk); #1 pru_start_i = 1'b1;
            @(posedge clk); #1 pru_start_i = 1'b0;
        end
        for (int i = 0; i < nd; i++) begin
            @(posedge clk); #1 pru_done_i = 1'b1;
            @(posedge clk); #1 pru_done_i = 1'b0;
        end
    endtask

    task automatic rd(input logic [31:0] off, input logic [31:0] exp,
                      input string nm);
        acc(2'b01, BASE + off, 32'h0, exp, 1'b1, 0, 3'b000, nm);
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] wd,
                      input logic [2:0] ev, input string nm);
        acc(2'b10, BASE + off, wd, 32'h0, 1'b1, 0, ev, nm);
    endtask

    initial begin
        tbl[0]  = '{2'b01, BASE + 32'h4,  32'h0, 32'h3, 1'b1};
        tbl[1]  = '{2'b01, BASE + 32'h8,  32'h0, 32'h2, 1'b1};
        tbl[2]  = '{2'b01, BASE + 32'h0,  32'h0, 32'h4, 1'b1};
        tbl[3]  = '{2'b01, BASE + 32'hC,  32'h0, 32'h0, 1'b1};
        tbl[4]  = '{2'b01, BASE + 32'h10, 32'h0, 32'h0, 1'b0};
        tbl[5]  = '{2'b01, 32'h0,         32'h0, 32'h0, 1'b0};
        tbl[6]  = '{2'b10, 32'h8,         32'h4, 32'h0, 1'b0};
        tbl[7]  = '{2'b10, BASE + 32'h24, 32'h4, 32'h0, 1'b0};
        tbl[8]  = '{2'b01, BASE + 32'h4,  32'h0, 32'h3, 1'b1};
        tbl[9]  = '{2'b01, BASE + 32'h8,  32'h0, 32'h2, 1'b1};
        tbl[10] = '{2'b01, BASE + 32'h0,  32'h0, 32'h4, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        chk("reset ack", 32'(b_ack_o), 32'd0);
        chk("reset data", b_data_o, 32'h0);
`ifdef PRU_IRQ_EN
        chk("reset irq", 32'(pru_irq_o), 32'd0);
`endif
        rst_n = 1'b1;

        acc(2'b01, BASE, 32'h0, 32'h0, 1'b1, 5, 3'b000, "first_read_hold");

        pulses(3, 2);
        for (int i = 0; i < 11; i++)
            acc(tbl[i].mode, tbl[i].addr, tbl[i].wdata, tbl[i].exp,
                tbl[i].ack, 0, 3'b000, $sformatf("vec%0d", i));

        @(posedge clk); #1 pru_busy_i = 1'b1;
        repeat (100) @(posedge clk);
        #1 pru_busy_i = 1'b0;
        rd(32'hC, 32'd100, "busy100");

        wr(32'h4, 32'hFFFF_FFFF, 3'b000, "wr_clr_cnt");
        rd(32'h4, 32'h0, "start_cleared");
        rd(32'h8, 32'h0, "done_cleared");
        rd(32'hC, 32'h0, "busy_cleared");
        rd(32'h0, 32'h4, "sticky_kept");

        wr(32'h0, 32'h4, 3'b010, "wr_sticky_vs_done");
        rd(32'h0, 32'h4, "sticky_event_wins");
        rd(32'h8, 32'h1, "done_cnt_one");
        wr(32'h0, 32'h4, 3'b000, "wr_sticky_clr");
        rd(32'h0, 32'h0, "sticky_cleared");

        wr(32'hC, 32'h0, 3'b111, "wr_clr_vs_events");
        rd(32'h4, 32'h1, "start_event_wins");
        rd(32'h8, 32'h1, "done_event_wins");
        rd(32'hC, 32'h1, "busy_event_wins");
        rd(32'h0, 32'h4, "sticky_set_again");

        acc(2'b11, BASE, 32'h4, 32'h0, 1'b1, 0, 3'b000, "rd_wr_both");
        rd(32'h0, 32'h0, "both_is_write");

        wr(32'h8, 32'h0, 3'b000, "wr_clr_for_wrap");
        @(posedge clk); #1 pru_start_i = 1'b1;
        repeat (15) @(posedge clk);
        #1 pru_start_i = 1'b0;
        rd(32'h4, 32'hF, "start_max");
        pulses(1, 0);
        rd(32'h4, 32'h0, "start_wrap");

        pulses(0, 1);
        @(posedge clk); #1;
        b_addr_i = BASE + 32'h8;
        b_read_i = 1'b1;
        @(posedge clk); #1;
        chk("mid_ack_before_rst", 32'(b_ack_o), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ack", 32'(b_ack_o), 32'd0);
        chk("mid_rst_data", b_data_o, 32'h0);
        b_read_i = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        rd(32'h8, 32'h0, "rst_done_cnt");
        rd(32'h0, 32'h0, "rst_sticky");

`ifdef PRU_IRQ_EN
        wr(32'h0, 32'h1, 3'b000, "wr_irq_en");
        rd(32'h0, 32'h1, "irq_en_read");
        @(posedge clk); #1 pru_done_i = 1'b1;
        @(posedge clk); #1 pru_done_i = 1'b0;
        chk("irq_not_yet", 32'(pru_irq_o), 32'd0);
        @(posedge clk); #1;
        chk("irq_asserted", 32'(pru_irq_o), 32'd1);
        rd(32'h0, 32'h5, "irq_status");
        wr(32'h0, 32'h5, 3'b000, "wr_irq_clr");
        repeat (2) @(posedge clk);
        #1;
        chk("irq_cleared", 32'(pru_irq_o), 32'd0);
        rd(32'h0, 32'h1, "irq_en_kept");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
